// File: rtl/shift_unit_pipe_pkg.sv
// shift_pkg: shared types for the pipelined barrel shifter.
//   shift_op_e : 3-bit operation encoding (101..111 are illegal)
//   shamt_w()  : number of shift-amount bits (and shift levels) for a width
//   op_legal() : true for the five defined operations
package shift_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  localparam int OP_W = 3;

  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/shift_unit_pipe_level.sv
// shift_level: one combinational level of the barrel shifter. When en is set
// it shifts/rotates data by the constant 2^K according to op; otherwise, or
// for an illegal op, data passes through unchanged.
//   data   : operand entering this level
//   en     : shift-amount bit K of the request
//   op     : operation (shift_op_e encoding)
//   sign   : original operand MSB, used as SRA fill at every level
//   result : operand leaving this level
module shift_level
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int K    = 0
) (
  input  logic [XLEN-1:0] data,
  input  logic            en,
  input  logic [OP_W-1:0] op,
  input  logic            sign,
  output logic [XLEN-1:0] result
);

  localparam int S = 1 << K;

  always_comb begin
    result = data;
    if (en) begin
      case (op)
        OP_SLL:  result = {data[XLEN-S-1:0], {S{1'b0}}};
        OP_SRL:  result = {{S{1'b0}}, data[XLEN-1:S]};
        OP_SRA:  result = {{S{sign}}, data[XLEN-1:S]};
        OP_ROL:  result = {data[XLEN-S-1:0], data[XLEN-1:XLEN-S]};
        OP_ROR:  result = {data[S-1:0], data[XLEN-1:S]};
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with a
// pass-through tag. log2(XLEN) shift levels are spread across PIPE_STAGES
// register stages; latency is PIPE_STAGES cycles, throughput one per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : request handshake
//   in_op/in_data/in_shamt/in_tag : request payload
//   out_valid/out_ready : result handshake
//   out_data/out_tag/out_op_err   : result payload (err set for illegal op)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_valid/out_valid, once raised, are held with a stable
// payload until the transfer; in_ready depends only on internal stage state
// and out_ready, never on in_valid, so there is no in_valid->out_valid path.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_data,
  input  logic [XLEN-1:0]  in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_op_err
);

  localparam int SHAMT_W = shamt_w(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [SHAMT_W-1:0] sh;
    logic [OP_W-1:0]    op;
    logic               sign;
    logic [TAG_W-1:0]   tag;
    logic               err;
  } stage_payload_t;

  // Stage that hosts shift level k.
  function automatic int stage_of(input int k);
    return (k * PIPE_STAGES) / SHAMT_W;
  endfunction

  // Highest level hosted by stage s, or -1 if the stage has no level.
  function automatic int last_level(input int s);
    int r;
    r = -1;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (stage_of(k) == s) r = k;
    end
    return r;
  endfunction

  function automatic stage_payload_t with_data(input stage_payload_t p,
                                               input logic [XLEN-1:0] d);
    stage_payload_t r;
    r      = p;
    r.data = d;
    return r;
  endfunction

  stage_payload_t         in_payload;
  stage_payload_t         src     [PIPE_STAGES];  // payload entering stage i
  stage_payload_t         stage_d [PIPE_STAGES];  // after stage i's levels
  stage_payload_t         stage_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] src_valid;
  logic [PIPE_STAGES-1:0] stage_valid;
  logic [PIPE_STAGES-1:0] stage_load;
  logic                   in_illegal;

  assign in_illegal = !op_legal(in_op);

  // An illegal request enters with a zero operand; every level passes an
  // illegal op through untouched, so it leaves as 0 with err set.
  always_comb begin
    in_payload      = '0;
    in_payload.data = in_illegal ? '0 : in_data;
    in_payload.sh   = in_shamt[SHAMT_W-1:0];
    in_payload.op   = in_op;
    in_payload.sign = in_data[XLEN-1];
    in_payload.tag  = in_tag;
    in_payload.err  = in_illegal;
  end

  // A stage loads when empty or when its occupant moves on this cycle.
  always_comb begin
    stage_load = '0;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      if (i == PIPE_STAGES - 1) stage_load[i] = !stage_valid[i] || out_ready;
      else                      stage_load[i] = !stage_valid[i] || stage_load[i+1];
    end
  end

  assign in_ready = stage_load[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (stage_load[i]) stage_valid[i] <= src_valid[i];
      end
    end
  end

  // Shift levels: the first level of a stage reads that stage's source
  // payload, later levels in the same stage chain combinationally.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
    localparam int ST = stage_of(k);
    logic [XLEN-1:0] lvl_in;
    logic [XLEN-1:0] lvl_out;

    if (k == 0 || stage_of(k - 1) != ST) begin : g_first
      assign lvl_in = src[ST].data;
    end else begin : g_chain
      assign lvl_in = g_level[k-1].lvl_out;
    end

    shift_level #(
      .XLEN (XLEN),
      .K    (k)
    ) u_level (
      .data   (lvl_in),
      .en     (src[ST].sh[k]),
      .op     (src[ST].op),
      .sign   (src[ST].sign),
      .result (lvl_out)
    );
  end

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    localparam int LAST = last_level(i);
    stage_payload_t q;

    if (i == 0) begin : g_src_in
      assign src[i]       = in_payload;
      assign src_valid[i] = in_valid;
    end else begin : g_src_prev
      assign src[i]       = stage_q[i-1];
      assign src_valid[i] = stage_valid[i-1];
    end

    if (LAST >= 0) begin : g_shift
      assign stage_d[i] = with_data(src[i], g_level[LAST].lvl_out);
    end else begin : g_pass
      assign stage_d[i] = src[i];
    end

    // Only the last stage drives outputs, so only it needs a reset value.
    // The payload is captured only with a real entry so a held result stays
    // stable while the stage is stalled.
    if (i == PIPE_STAGES - 1) begin : g_out_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                q <= '0;
        else if (stage_load[i] && src_valid[i]) q <= stage_d[i];
      end
    end else begin : g_mid_reg
      always_ff @(posedge clk) begin
        if (stage_load[i] && src_valid[i]) q <= stage_d[i];
      end
    end

    assign stage_q[i] = q;
  end

  assign out_valid  = stage_valid[PIPE_STAGES-1];
  assign out_data   = stage_q[PIPE_STAGES-1].data;
  assign out_tag    = stage_q[PIPE_STAGES-1].tag;
  assign out_op_err = stage_q[PIPE_STAGES-1].err;

  // Upper shamt bits are ignored by definition; the last stage's control
  // fields have no consumer.
  logic unused_bits;
  assign unused_bits = ^{in_shamt[XLEN-1:SHAMT_W], stage_q[PIPE_STAGES-1].sh,
                         stage_q[PIPE_STAGES-1].op, stage_q[PIPE_STAGES-1].sign};

endmodule
